// File: rtl/multi_channel_blinker.sv
// multi_channel_blinker
// CHANNELS independent LED/IO outputs driven from a shared millisecond timebase.
// Each channel is off, on, blinking with a programmable half-period (in ticks),
// or PWM-dimmed against a free-running counter shared by every channel.
// Configuration arrives on a single-cycle write port with no back-pressure.

module multi_channel_blinker #(
   parameter int CHANNELS     = 4,
   parameter int CLK_FREQ     = 27_000_000,
   parameter int TICK_HZ      = 1000,
   parameter int PERIOD_W     = 16,
   parameter int DUTY_W       = 8,
   parameter int RESET_PERIOD = 500,
   localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                Clock,
   input  logic                Reset_n,
   input  logic                cfg_wr,
   input  logic [CH_W-1:0]     cfg_ch,
   input  logic [1:0]          cfg_mode,
   input  logic [PERIOD_W-1:0] cfg_period,
   input  logic [DUTY_W-1:0]   cfg_duty,
   output logic                tick,
   output logic [CHANNELS-1:0] IO_voltage
);

   localparam int DIV   = CLK_FREQ / TICK_HZ;
   localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [PRE_W-1:0]    PRE_MAX     = PRE_W'(DIV - 1);
   localparam logic [PRE_W-1:0]    PRE_ONE     = PRE_W'(1);
   localparam logic [PRE_W-1:0]    PRE_ZERO    = {PRE_W{1'b0}};
   localparam logic [PERIOD_W-1:0] PER_ZERO    = {PERIOD_W{1'b0}};
   localparam logic [PERIOD_W-1:0] PER_ONE     = PERIOD_W'(1);
   localparam logic [PERIOD_W-1:0] PER_RESET   = PERIOD_W'(RESET_PERIOD);
   localparam logic [DUTY_W-1:0]   DUTY_ZERO   = {DUTY_W{1'b0}};
   localparam logic [DUTY_W-1:0]   DUTY_ONE    = DUTY_W'(1);

   localparam logic [1:0] MODE_OFF   = 2'b00;
   localparam logic [1:0] MODE_ON    = 2'b01;
   localparam logic [1:0] MODE_BLINK = 2'b10;
   localparam logic [1:0] MODE_PWM   = 2'b11;

   logic [PRE_W-1:0]    prescaler;
   logic [DUTY_W-1:0]   pwm_cnt;
   logic [CHANNELS-1:0] next_io;

   // Timebase: prescaler wraps every DIV cycles, tick follows the max count by one cycle.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         prescaler <= PRE_ZERO;
         tick      <= 1'b0;
      end else begin
         if (prescaler == PRE_MAX) begin
            prescaler <= PRE_ZERO;
         end else begin
            prescaler <= prescaler + PRE_ONE;
         end
         tick <= (prescaler == PRE_MAX);
      end
   end

   // Shared free-running PWM counter keeps every dimmed channel phase-aligned.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         pwm_cnt <= DUTY_ZERO;
      end else begin
         pwm_cnt <= pwm_cnt + DUTY_ONE;
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [1:0]          mode;
      logic [PERIOD_W-1:0] period;
      logic [PERIOD_W-1:0] count;
      logic [PERIOD_W-1:0] last_count;
      logic [DUTY_W-1:0]   duty;
      logic                phase;
      logic                wr_hit;
      logic                out_next;

      // An out-of-range cfg_ch never equals any channel index, so it is dropped here.
      assign wr_hit = cfg_wr && (cfg_ch == CH_W'(i));

      // A half-period of 0 behaves as 1: toggle on every tick.
      assign last_count = (period == PER_ZERO) ? PER_ZERO : (period - PER_ONE);

      // Channel config registers and blink engine; a write beats a coincident tick.
      always_ff @(posedge Clock or negedge Reset_n) begin
         if (!Reset_n) begin
            mode   <= MODE_OFF;
            period <= PER_RESET;
            duty   <= DUTY_ZERO;
            count  <= PER_ZERO;
            phase  <= 1'b0;
         end else if (wr_hit) begin
            mode   <= cfg_mode;
            period <= cfg_period;
            duty   <= cfg_duty;
            count  <= PER_ZERO;
            phase  <= 1'b0;
         end else if (mode != MODE_BLINK) begin
            count  <= PER_ZERO;
            phase  <= 1'b0;
         end else if (tick) begin
            if (count == last_count) begin
               count <= PER_ZERO;
               phase <= ~phase;
            end else begin
               count <= count + PER_ONE;
            end
         end else begin
            count <= count;
            phase <= phase;
         end
      end

      // Output level selected by the channel mode.
      always_comb begin
         out_next = 1'b0;
         case (mode)
            MODE_OFF:   out_next = 1'b0;
            MODE_ON:    out_next = 1'b1;
            MODE_BLINK: out_next = phase;
            MODE_PWM:   out_next = (pwm_cnt < duty);
            default:    out_next = 1'b0;
         endcase
      end

      assign next_io[i] = out_next;
   end

   // Registered pin drive for all channels.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         IO_voltage <= {CHANNELS{1'b0}};
      end else begin
         IO_voltage <= next_io;
      end
   end

endmodule
